ycbcr_ram_param_init: RTL and testbench

- Parametrised single-clock, simple-dual-port colour-coefficient/line RAM for the display frame-buffer path.
- Generalises the fixed 512x8 initialised RAM with configurable data width and depth.
- Contents are loaded at run time by an internal init sequencer, not by build-time INIT strings: a coefficient vector is written to the low addresses and a fill value to the rest.
- Supports re-initialisation on request and gates user access until init completes.

---
 rtl/ycbcr_ram_param_init.sv | 197 +++++++++++++++++++
 tb/tb_ycbcr_ram_param_init.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_ram_param_init.sv
// ycbcr_ram_param_init
// Simple-dual-port coefficient/line RAM for the display frame-buffer path.
// An internal sequencer loads the contents at run time. The first INIT_COUNT
// words come from INIT_VEC and every remaining word gets FILL_VALUE.
// User access is held off until that load has finished.
//
// Optional build macro YCBCR_RAM_OREG_EN adds an output pipeline register.
// This gives a 2-cycle read latency. When the macro is undefined, the read
// latency is 1 cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | sequencer writes mem[iptr], user reads/writes ignored
// READY | sequencer idle, user port live once init_done is high

module ycbcr_ram_param_init #(
    parameter int                               DATA_WIDTH = 8,
    parameter int                               ADDR_WIDTH = 9,
    parameter int                               INIT_COUNT = 9,
    parameter logic [DATA_WIDTH*INIT_COUNT-1:0] INIT_VEC   = 72'h6df028223590f05a51,
    parameter logic [DATA_WIDTH-1:0]            FILL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reinit,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  init_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // INIT_COUNT beyond DEPTH is clamped; the check below reports it.
    localparam int LOAD_COUNT = (INIT_COUNT > DEPTH) ? DEPTH : INIT_COUNT;
    // iptr carries one spare bit so DEPTH itself is representable.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] IPTR_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   iptr_q, iptr_d;
    logic                  init_done_q, init_done_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  access_ok;
    logic                  user_we;
    logic                  user_re;
    logic [DATA_WIDTH-1:0] init_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // User port gating: live only once init has been reported done.
    // A reinit pulse drops any user access in the same cycle.
    always_comb begin
        access_ok = (state_q == ST_READY) && init_done_q;
        user_we   = access_ok && write_en && !reinit;
        user_re   = access_ok && read_en  && !reinit;
    end

    // Word the sequencer writes at iptr: the coefficient vector, then the fill value.
    always_comb begin
        init_word = FILL_VALUE;
        for (int k = 0; k < LOAD_COUNT; k++) begin
            if (iptr_q == (ADDR_WIDTH + 1)'(k)) begin
                init_word = INIT_VEC[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // RAM write port mux: the sequencer owns the port in INIT, the user owns it in READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = din;
        if (state_q == ST_INIT) begin
            mem_we    = !rst;
            mem_waddr = iptr_q[ADDR_WIDTH-1:0];
            mem_wdata = init_word;
        end else if (user_we) begin
            mem_we = 1'b1;
        end
    end

    // Next-state logic for the sequencer and its registered status outputs.
    always_comb begin
        state_d = state_q;
        iptr_d  = iptr_q;
        unique case (state_q)
            ST_INIT: begin
                if (reinit) begin
                    iptr_d = '0;
                end else if (iptr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    iptr_d  = '0;
                end else begin
                    iptr_d = iptr_q + IPTR_ONE;
                end
            end
            ST_READY: begin
                if (reinit) begin
                    state_d = ST_INIT;
                    iptr_d  = '0;
                end
            end
        endcase
        // init_done trails entry into READY by one cycle.
        init_done_d = (state_q == ST_READY) && !reinit;
        rd_valid_d  = user_re;
    end

    // Sequencer state and status flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            iptr_q      <= '0;
            init_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            iptr_q      <= iptr_d;
            init_done_q <= init_done_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // RAM write port; there is no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Synchronous RAM read; a same-cycle write to raddr is not seen (old data).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (user_re) begin
            rd_data_q <= mem[raddr];
        end
    end

`ifndef SYNTHESIS
    // Report an oversized INIT_COUNT while reset is applied.
    always_ff @(posedge clk) begin
        if (rst && (INIT_COUNT > DEPTH)) begin
            $error("ycbcr_ram_param_init: INIT_COUNT %0d exceeds DEPTH %0d, clamped", INIT_COUNT, DEPTH);
        end
    end
`endif

`ifdef YCBCR_RAM_OREG_EN
    logic [DATA_WIDTH-1:0] oreg_data_q, oreg_data_d;
    logic                  oreg_valid_q, oreg_valid_d;

    // Output stage next value: load only on a valid read, clear on reinit.
    always_comb begin
        oreg_data_d  = rd_valid_q ? rd_data_q : oreg_data_q;
        oreg_valid_d = rd_valid_q;
        if (reinit) begin
            oreg_data_d  = '0;
            oreg_valid_d = 1'b0;
        end
    end

    // Extra output pipeline stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_data_q  <= '0;
            oreg_valid_q <= 1'b0;
        end else begin
            oreg_data_q  <= oreg_data_d;
            oreg_valid_q <= oreg_valid_d;
        end
    end

    assign dout       = oreg_data_q;
    assign dout_valid = oreg_valid_q;
`else
    assign dout       = rd_data_q;
    assign dout_valid = rd_valid_q;
`endif

    assign init_done = init_done_q;

endmodule

// File: tb/tb_ycbcr_ram_param_init.sv
// Directed testbench for ycbcr_ram_param_init. It instantiates two builds:
// the default 512x8 build and a 16x16 build with INIT_COUNT = 2.
module tb_ycbcr_ram_param_init;

`ifdef YCBCR_RAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, reinit, write_en, read_en;
    logic [8:0]  waddr, raddr;
    logic [7:0]  din, dout;
    logic        dout_valid, init_done;

    logic        reinit2, we2, re2;
    logic [3:0]  waddr2, raddr2;
    logic [15:0] din2, dout2;
    logic        dv2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ycbcr_ram_param_init dut (
        .clk(clk), .rst(rst), .reinit(reinit),
        .write_en(write_en), .waddr(waddr), .din(din),
        .read_en(read_en), .raddr(raddr),
        .dout(dout), .dout_valid(dout_valid), .init_done(init_done)
    );

    ycbcr_ram_param_init #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .INIT_COUNT(2),
        .INIT_VEC(32'hBEEF_1234), .FILL_VALUE(16'h00AA)
    ) dut2 (
        .clk(clk), .rst(rst), .reinit(reinit2),
        .write_en(we2), .waddr(waddr2), .din(din2),
        .read_en(re2), .raddr(raddr2),
        .dout(dout2), .dout_valid(dv2), .init_done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one read on the default instance and sample after LAT edges.
    task automatic rd(input logic [8:0] a, output logic [7:0] d, output logic v);
        read_en = 1'b1;
        raddr   = a;
        tick();
        read_en = 1'b0;
        repeat (LAT - 1) tick();
        d = dout;
        v = dout_valid;
    endtask

    task automatic rd2(input logic [3:0] a, output logic [15:0] d, output logic v);
        re2    = 1'b1;
        raddr2 = a;
        tick();
        re2 = 1'b0;
        repeat (LAT - 1) tick();
        d = dout2;
        v = dv2;
    endtask

    // Cycle 0 is the first edge after the sampling edge of rst/reinit.
    task automatic wait_done(output int rise, output int rise2, output logic saw_valid);
        rise      = -1;
        rise2     = -1;
        saw_valid = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (dout_valid) saw_valid = 1'b1;
            if (done2 && rise2 < 0) rise2 = k;
            if (init_done) begin
                rise = k;
                break;
            end
        end
    endtask

    logic [7:0]  exp_tab [9] = '{8'h51, 8'h5a, 8'hf0, 8'h90, 8'h35, 8'h22, 8'h28, 8'hf0, 8'h6d};
    logic [7:0]  d;
    logic [15:0] d16;
    logic        v, saw;
    int          rise, rise2;

    initial begin
        rst = 1'b1; reinit = 1'b0; write_en = 1'b0; read_en = 1'b0;
        waddr = '0; raddr = '0; din = '0;
        reinit2 = 1'b0; we2 = 1'b0; re2 = 1'b0; waddr2 = '0; raddr2 = '0; din2 = '0;
        repeat (3) tick();
        chk("rst_init_done", init_done, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);

        rst = 1'b0;
        wait_done(rise, rise2, saw);
        chk("init_rise_cycle", rise, 512);
        chk("init2_rise_cycle", rise2, 16);

        for (int i = 0; i < 9; i++) begin
            rd(9'(i), d, v);
            chk($sformatf("coef_%0d", i), d, exp_tab[i]);
            chk($sformatf("coef_valid_%0d", i), v, 1);
        end
        rd(9'd9, d, v);   chk("fill_9", d, 8'h00);
        rd(9'd511, d, v); chk("fill_511", d, 8'h00);

        // Plain write, then read-back, then the hold behaviour.
        write_en = 1'b1; waddr = 9'd100; din = 8'hA5;
        tick();
        write_en = 1'b0;
        read_en = 1'b1; raddr = 9'd100;
        tick();
        read_en = 1'b0;
        if (LAT == 2) chk("lat2_early_valid", dout_valid, 0);
        repeat (LAT - 1) tick();
        chk("wr100_data", dout, 8'hA5);
        chk("wr100_valid", dout_valid, 1);
        tick();
        chk("idle_valid", dout_valid, 0);
        chk("idle_hold", dout, 8'hA5);

        // Same-cycle write and read of one address return the old data.
        write_en = 1'b1; waddr = 9'd0; din = 8'h3C;
        read_en = 1'b1; raddr = 9'd0;
        tick();
        write_en = 1'b0; read_en = 1'b0;
        repeat (LAT - 1) tick();
        chk("collide_old", dout, 8'h51);
        chk("collide_valid", dout_valid, 1);
        rd(9'd0, d, v);
        chk("collide_new", d, 8'h3C);

        // Overwrite addr 3, then reinit while user traffic targets addr 5.
        write_en = 1'b1; waddr = 9'd3; din = 8'h00;
        tick();
        write_en = 1'b0;
        rd(9'd3, d, v);
        chk("addr3_zero", d, 8'h00);
        repeat (LAT) tick();
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        chk("reinit_drop", init_done, 0);
        chk("reinit_valid", dout_valid, 0);
        write_en = 1'b1; waddr = 9'd5; din = 8'hFF;
        read_en = 1'b1; raddr = 9'd5;
        wait_done(rise, rise2, saw);
        write_en = 1'b0; read_en = 1'b0;
        chk("reinit_rise_cycle", rise, 512);
        chk("init_no_valid", saw, 0);
        rd(9'd5, d, v);   chk("addr5_after_init", d, 8'h22);
        rd(9'd3, d, v);   chk("addr3_restored", d, 8'h90);
        rd(9'd100, d, v); chk("addr100_refilled", d, 8'h00);

        // Reset partway through init restarts the sequence from scratch.
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        repeat (200) tick();
        chk("mid_init_low", init_done, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_done(rise, rise2, saw);
        chk("rst_mid_rise_cycle", rise, 512);
        chk("rst_mid_rise2_cycle", rise2, 16);
        rd(9'd8, d, v);   chk("addr8_after_rst", d, 8'h6d);

        // Wide/shallow build: two vector words, then the fill value.
        rd2(4'd0, d16, v);  chk("w16_addr0", d16, 16'h1234); chk("w16_valid", v, 1);
        rd2(4'd1, d16, v);  chk("w16_addr1", d16, 16'hBEEF);
        rd2(4'd2, d16, v);  chk("w16_addr2", d16, 16'h00AA);
        rd2(4'd15, d16, v); chk("w16_addr15", d16, 16'h00AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
